// File: rtl/residual_merge.sv
// Stride-2 residual merge: averages each 2x2 shortcut patch, buffers it until the macro
// result arrives, then adds, saturates and tags the pixel position. Option: RESIDUAL_RELU_EN.
module residual_merge #(
    parameter int FM_DEPTH     = 64,
    parameter int OUT_FM_WIDTH = 28,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              verticle_sync,
    input  logic                              mode_in,
    input  logic                              res_valid,
    input  logic [FM_DEPTH*64-1:0]            res_in,
    input  logic                              latch_to_macro,
    input  logic [FM_DEPTH*16-1:0]            macro_out,
    output logic [FM_DEPTH*16-1:0]            data_out,
    output logic                              data_out_valid,
    output logic                              vs_out,
    output logic [$clog2(OUT_FM_WIDTH)-1:0]   out_col,
    output logic [$clog2(OUT_FM_WIDTH)-1:0]   out_row,
    output logic                              err_overflow,
    output logic                              err_underflow
);

    localparam int POS_W = $clog2(OUT_FM_WIDTH);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(OUT_FM_WIDTH - 1);

    logic                    flush;
    logic                    lat_d;
    logic                    pop_evt;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic                    do_push;
    logic                    do_pop;
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CNT_W-1:0]        count;
    logic [FM_DEPTH*16-1:0]  mem [FIFO_DEPTH];
    logic [FM_DEPTH*16-1:0]  push_data;
    logic [FM_DEPTH*16-1:0]  head;
    logic [FM_DEPTH*16-1:0]  merged;
    logic [POS_W-1:0]        nxt_col;
    logic [POS_W-1:0]        nxt_row;

    assign flush      = verticle_sync | ~mode_in;
    assign pop_evt    = lat_d & ~latch_to_macro;
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push    = res_valid & (~fifo_full | pop_evt);
    assign do_pop     = pop_evt & ~fifo_empty;
    assign head       = fifo_empty ? '0 : mem[rd_ptr];

    always_comb begin
        logic signed [17:0] sum;
        logic signed [17:0] avg;
        logic signed [15:0] lane;
        push_data = '0;
        for (int c = 0; c < FM_DEPTH; c++) begin
            sum = '0;
            for (int l = 0; l < 4; l++) begin
                lane = res_in[(c*4+l)*16 +: 16];
                sum  = sum + 18'(lane);
            end
            avg = sum >>> 2;
            push_data[c*16 +: 16] = avg[15:0];
        end
    end

    always_comb begin
        logic signed [16:0] s17;
        logic signed [15:0] mac;
        logic signed [15:0] sc;
        logic        [15:0] res;
        merged = '0;
        for (int c = 0; c < FM_DEPTH; c++) begin
            mac = macro_out[c*16 +: 16];
            sc  = head[c*16 +: 16];
            s17 = 17'(mac) + 17'(sc);
            case (s17[16:15])
                2'b01:   res = 16'h7fff;
                2'b10:   res = 16'h8000;
                default: res = s17[15:0];
            endcase
`ifdef RESIDUAL_RELU_EN
            if (res[15]) res = '0;
`else
`endif
            merged[c*16 +: 16] = res;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !flush && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            lat_d          <= 1'b0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            vs_out         <= 1'b0;
            out_col        <= '0;
            out_row        <= '0;
            nxt_col        <= '0;
            nxt_row        <= '0;
            if (rst) begin
                err_overflow  <= 1'b0;
                err_underflow <= 1'b0;
            end
        end else begin
            lat_d          <= latch_to_macro;
            data_out_valid <= pop_evt;
            vs_out         <= pop_evt && (nxt_col == '0) && (nxt_row == '0);
            if (pop_evt) begin
                data_out <= merged;
                out_col  <= nxt_col;
                out_row  <= nxt_row;
                if (nxt_col == LAST_POS) begin
                    nxt_col <= '0;
                    nxt_row <= (nxt_row == LAST_POS) ? '0 : nxt_row + 1'b1;
                end else begin
                    nxt_col <= nxt_col + 1'b1;
                end
            end
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
            if (res_valid && fifo_full && !pop_evt) err_overflow  <= 1'b1;
            if (pop_evt && fifo_empty)              err_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_residual_merge.sv
// Directed self-checking bench for residual_merge: table of single-window merges
// followed by hand-written FIFO, flush and frame-wrap sequences.
module tb_residual_merge;

    localparam int FM  = 64;
    localparam int W   = 28;
    localparam int PW  = $clog2(W);

    logic              clk = 1'b0;
    logic              rst;
    logic              verticle_sync;
    logic              mode_in;
    logic              res_valid;
    logic [FM*64-1:0]  res_in;
    logic              latch_to_macro;
    logic [FM*16-1:0]  macro_out;
    logic [FM*16-1:0]  data_out;
    logic              data_out_valid;
    logic              vs_out;
    logic [PW-1:0]     out_col;
    logic [PW-1:0]     out_row;
    logic              err_overflow;
    logic              err_underflow;

    int total = 0;
    int bad   = 0;
    int vs_count;

    residual_merge #(.FM_DEPTH(FM), .OUT_FM_WIDTH(W), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .verticle_sync(verticle_sync), .mode_in(mode_in),
        .res_valid(res_valid), .res_in(res_in), .latch_to_macro(latch_to_macro),
        .macro_out(macro_out), .data_out(data_out), .data_out_valid(data_out_valid),
        .vs_out(vs_out), .out_col(out_col), .out_row(out_row),
        .err_overflow(err_overflow), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] l0, l1, l2, l3;
        logic signed [15:0] mac;
        int                 exp_even;
    } vec_t;

    vec_t vecs [7];

    function automatic int expv(int v);
`ifdef RESIDUAL_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    function automatic int ch_val(int c);
        logic signed [15:0] v;
        v = data_out[c*16 +: 16];
        return int'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Even channels carry the patch, odd channels carry a zero patch.
    task automatic set_res(input logic signed [15:0] l0, l1, l2, l3);
        for (int c = 0; c < FM; c++) begin
            if (c % 2 == 0) begin
                res_in[(c*4+0)*16 +: 16] = l0;
                res_in[(c*4+1)*16 +: 16] = l1;
                res_in[(c*4+2)*16 +: 16] = l2;
                res_in[(c*4+3)*16 +: 16] = l3;
            end else begin
                res_in[c*64 +: 64] = '0;
            end
        end
    endtask

    task automatic set_mac(input logic signed [15:0] m);
        for (int c = 0; c < FM; c++) macro_out[c*16 +: 16] = m;
    endtask

    task automatic push(input logic signed [15:0] v);
        set_res(v, v, v, v);
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
    endtask

    task automatic pop_merge(input logic signed [15:0] m);
        latch_to_macro = 1'b1;
        tick();
        latch_to_macro = 1'b0;
        set_mac(m);
        tick();
    endtask

    task automatic applyStimulus(input vec_t v);
        set_res(v.l0, v.l1, v.l2, v.l3);
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        latch_to_macro = 1'b1;
        repeat (9) tick();
        latch_to_macro = 1'b0;
        set_mac(v.mac);
        tick();
    endtask

    initial begin
        vecs[0] = '{16'sd4, 16'sd8, 16'sd12, 16'sd16, 16'sd100, 110};
        vecs[1] = '{-16'sd1, -16'sd2, -16'sd2, -16'sd2, 16'sd0, -2};
        vecs[2] = '{16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767, 32767};
        vecs[3] = '{-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768, -32768};
        vecs[4] = '{16'sd1, 16'sd1, 16'sd1, 16'sd0, -16'sd5, -5};
        vecs[5] = '{-16'sd3, 16'sd0, 16'sd0, 16'sd0, 16'sd1000, 999};
        vecs[6] = '{16'sd100, -16'sd200, 16'sd300, -16'sd400, -16'sd32760, -32768};

        rst = 1'b1; verticle_sync = 1'b0; mode_in = 1'b1; res_valid = 1'b0;
        res_in = '0; latch_to_macro = 1'b0; macro_out = '0;
        tick(); tick();
        checkOutput("reset_valid", int'(data_out_valid), 0);
        checkOutput("reset_data", ch_val(0), 0);
        checkOutput("reset_flags", int'({err_overflow, err_underflow}), 0);
        checkOutput("reset_pos", int'({out_col, out_row}), 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d_valid", i), int'(data_out_valid), 1);
            checkOutput($sformatf("vec%0d_ch0", i), ch_val(0), expv(vecs[i].exp_even));
            checkOutput($sformatf("vec%0d_ch62", i), ch_val(FM-2), expv(vecs[i].exp_even));
            checkOutput($sformatf("vec%0d_ch63", i), ch_val(FM-1), expv(int'(vecs[i].mac)));
            checkOutput($sformatf("vec%0d_col", i), int'(out_col), i);
            checkOutput($sformatf("vec%0d_row", i), int'(out_row), 0);
            checkOutput($sformatf("vec%0d_vs", i), int'(vs_out), (i == 0) ? 1 : 0);
            tick();
            checkOutput($sformatf("vec%0d_pulse", i), int'(data_out_valid), 0);
        end
        checkOutput("table_no_flags", int'({err_overflow, err_underflow}), 0);

        // Overflow: third push into a two-entry FIFO is dropped.
        push(16'sd4); push(16'sd8);
        checkOutput("ovf_before", int'(err_overflow), 0);
        push(16'sd12);
        checkOutput("ovf_set", int'(err_overflow), 1);
        pop_merge(16'sd0);
        checkOutput("ovf_first", ch_val(0), 4);
        pop_merge(16'sd0);
        checkOutput("ovf_second", ch_val(0), 8);
        checkOutput("udf_before", int'(err_underflow), 0);
        pop_merge(16'sd0);
        checkOutput("udf_zero", ch_val(0), 0);
        checkOutput("udf_set", int'(err_underflow), 1);

        // Flags hold through frame flush; outputs clear.
        pop_merge(16'sd9);
        verticle_sync = 1'b1;
        tick();
        verticle_sync = 1'b0;
        checkOutput("vs_flags_hold", int'({err_overflow, err_underflow}), 3);
        checkOutput("vs_data_clr", ch_val(0), 0);
        checkOutput("vs_valid_clr", int'(data_out_valid), 0);

        // Parameter-load mode also flushes the FIFO.
        push(16'sd40);
        mode_in = 1'b0;
        tick();
        mode_in = 1'b1;
        pop_merge(16'sd7);
        checkOutput("mode_flush", ch_val(0), 7);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("rst_flags_clr", int'({err_overflow, err_underflow}), 0);

        // Simultaneous push and pop with a full FIFO.
        push(16'sd4); push(16'sd8);
        latch_to_macro = 1'b1;
        tick();
        set_res(16'sd12, 16'sd12, 16'sd12, 16'sd12);
        res_valid = 1'b1; latch_to_macro = 1'b0; set_mac(16'sd0);
        tick();
        res_valid = 1'b0;
        checkOutput("full_pp_data", ch_val(0), 4);
        checkOutput("full_pp_noovf", int'(err_overflow), 0);
        pop_merge(16'sd0);
        checkOutput("full_pp_b", ch_val(0), 8);
        pop_merge(16'sd0);
        checkOutput("full_pp_c", ch_val(0), 12);
        checkOutput("full_pp_noudf", int'(err_underflow), 0);

        // Simultaneous push and pop with an empty FIFO: no bypass.
        rst = 1'b1; tick(); rst = 1'b0;
        latch_to_macro = 1'b1;
        tick();
        set_res(16'sd16, 16'sd16, 16'sd16, 16'sd16);
        res_valid = 1'b1; latch_to_macro = 1'b0; set_mac(16'sd5);
        tick();
        res_valid = 1'b0;
        checkOutput("empty_pp_data", ch_val(0), 5);
        checkOutput("empty_pp_udf", int'(err_underflow), 1);
        pop_merge(16'sd0);
        checkOutput("empty_pp_stored", ch_val(0), 16);

        // Mid-frame flush between push and pop.
        rst = 1'b1; tick(); rst = 1'b0;
        pop_merge(16'sd1); pop_merge(16'sd1);
        checkOutput("mid_col_adv", int'(out_col), 1);
        push(16'sd20);
        verticle_sync = 1'b1;
        tick();
        verticle_sync = 1'b0;
        checkOutput("mid_no_valid", int'(data_out_valid), 0);
        pop_merge(16'sd3);
        checkOutput("mid_data", ch_val(0), 3);
        checkOutput("mid_pos", int'({out_col, out_row}), 0);
        checkOutput("mid_vs", int'(vs_out), 1);
        latch_to_macro = 1'b1;
        tick();
        latch_to_macro = 1'b0; verticle_sync = 1'b1;
        tick();
        verticle_sync = 1'b0;
        checkOutput("inflight_drop", int'(data_out_valid), 0);
        tick();
        checkOutput("inflight_drop2", int'(data_out_valid), 0);

        // Full frame plus one pixel.
        rst = 1'b1; tick(); rst = 1'b0;
        vs_count = 0;
        for (int p = 0; p <= W*W; p++) begin
            pop_merge(16'sd1);
            if (vs_out) vs_count++;
            if (p == W-1) begin
                checkOutput("wrap_col27", int'(out_col), W-1);
                checkOutput("wrap_row0", int'(out_row), 0);
            end
            if (p == W) begin
                checkOutput("wrap_col0", int'(out_col), 0);
                checkOutput("wrap_row1", int'(out_row), 1);
            end
            if (p == W*W-1) checkOutput("last_pos", int'({out_col, out_row}), (27 << PW) | 27);
            if (p == W*W) begin
                checkOutput("frame2_pos", int'({out_col, out_row}), 0);
                checkOutput("frame2_vs", int'(vs_out), 1);
            end
        end
        checkOutput("vs_count", vs_count, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/residual_merge.md
Name: residual_merge

Overview:
- Downstream of the window/macro driver stage in the stride-2 residual path.
- Captures the 2x2 shortcut patch (res) for each conv window and reduces it to one 2x2-average shortcut per channel.
- When the CIM macro finishes the matching window (falling edge of latch_to_macro), adds the shortcut to the macro result, saturates, and emits one output pixel per channel with a frame-position tracker for the next layer.

Parameters:
FM_DEPTH, 64, number of channels (macro outputs and res lanes)
OUT_FM_WIDTH, 28, output feature-map width and height (square)
FIFO_DEPTH, 2, shortcut entries buffered between res capture and macro completion (power of 2, >=2)

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous active-high reset
verticle_sync  input  1  start-of-frame; flushes state like reset, except error flags
mode_in  input  1  0 = parameter load (block idle and flushed), 1 = calculate
res_valid  input  1  one-cycle pulse; res_in holds the current window's patch this cycle
res_in  input  16 x [FM_DEPTH][4]  signed 2x2 shortcut patch per channel
latch_to_macro  input  1  macro latch phase; falling edge marks macro result ready
macro_out  input  16 x [FM_DEPTH]  signed macro result per channel, valid in the cycle latch_to_macro falls
data_out  output  16 x [FM_DEPTH]  signed merged pixel per channel
data_out_valid  output  1  one-cycle pulse, data_out valid
vs_out  output  1  one-cycle pulse coincident with the first data_out_valid of a frame
out_col  output  clog2(OUT_FM_WIDTH)  column of the pixel on data_out
out_row  output  clog2(OUT_FM_WIDTH)  row of the pixel on data_out
err_overflow  output  1  sticky: res_valid arrived with the FIFO full
err_underflow  output  1  sticky: macro result arrived with the FIFO empty

Behaviour:
- Reset (rst=1): all outputs 0; FIFO empty; out_col = out_row = 0; latch edge register 0; error flags cleared.
- Flush (verticle_sync=1 or mode_in=0): same as reset, but err_overflow and err_underflow hold their values. A push or pop in a flush cycle is ignored.
- Shortcut computation, per channel, on res_valid:
  - sum = sign-extended 18-bit sum of the 4 lanes.
  - shortcut = sum >>> 2 (arithmetic shift, floor toward -inf), truncated to 16 bits (always fits).
  - Pushed into the FIFO in the same cycle, with no stall.
- Edge detect:
  - lat_d = latch_to_macro registered.
  - pop_evt = lat_d & ~latch_to_macro, evaluated combinationally in the falling-edge cycle.
- Merge on pop_evt:
  - Per channel: s17 = macro_out + FIFO head, 17-bit signed.
  - Saturate to [-32768, 32767].
  - Register into data_out; data_out_valid = 1 in the next cycle (latency 1 from the falling edge).
  - Pop the FIFO head.
- data_out holds its value until the next merge or flush.
- Empty FIFO on pop_evt: merge with shortcut = 0, still emit, set err_underflow.
- Full FIFO on res_valid without a simultaneous pop: drop the push, set err_overflow.
- Simultaneous push and pop:
  - Full FIFO: pop the old head and push the new entry; no overflow.
  - Empty FIFO: no bypass; merge uses 0 and flags underflow, and the new entry is stored.
- Position tracking:
  - out_col/out_row describe the pixel currently on data_out.
  - After each emitted pixel, out_col increments; it wraps OUT_FM_WIDTH-1 -> 0 with out_row+1.
  - out_row wraps OUT_FM_WIDTH-1 -> 0.
- vs_out = data_out_valid & (out_col==0) & (out_row==0).
- Reset or flush mid-operation: in-flight merge is discarded, and data_out_valid is 0 in the following cycle.

Optional Feature:
RESIDUAL_RELU_EN
- Defined: after saturation, negative results are forced to 0 (ReLU), and data_out is always >= 0.
- Undefined: the signed saturated value passes unchanged.
- Flags, latency and position tracking are identical in both builds.

Test Plan:
- Basic merge: res_in lanes {4,8,12,16} on ch0, macro_out ch0=100, latch falls 10 cycles later -> data_out[0]=110, data_out_valid 1 cycle after the fall, out_col=0, out_row=0, vs_out=1.
- Negative rounding: lanes {-1,-2,-2,-2} (sum -7), macro_out 0 -> data_out=-2 (floor). With RESIDUAL_RELU_EN -> 0.
- Saturation: shortcut lanes all 32767, macro_out 32767 -> 32767. Lanes all -32768, macro_out -32768 -> -32768.
- FIFO bounds:
  - Three res_valid pulses with no pop (FIFO_DEPTH=2) -> err_overflow=1, first two shortcuts survive.
  - Pop with the FIFO empty -> shortcut 0 used, err_underflow=1.
  - Flags stay set through verticle_sync, clear only on rst.
- Frame wrap: 28x28 merges -> out_col wraps 27->0 with out_row increment; after 784 pixels out_row=0, and vs_out pulses on pixel 0 and again on pixel 784.
- Mid-frame flush: assert verticle_sync one cycle after a push and before its pop -> FIFO empty, no data_out_valid. The next falling edge yields shortcut 0 and err_underflow=1; positions restart at 0,0.
